// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// The head entry (main) feeds the outputs directly; the skid entry catches the one
// beat that can arrive in the cycle after downstream stalls. in_ready is registered,
// so no combinational path runs from out_ready back to the upstream stage.
// Control and data travel on separate buses so that bubbles and flushes only need
// to clear control. Datapath storage is left alone unless CLEAR_DATA is set.

module pipe_stage_skid #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 276,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;

    logic                accept;
    logic                drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid & out_ready;

    // Register the occupancy state and the precomputed upstream ready.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        in_ready_q <= in_ready_d;
    end

    // Register the head and skid entries.
    always_ff @(posedge clk) begin
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
    end

    // Next occupancy. Reset wins over flush, and both empty the stage.
    always_comb begin
        state_d = state_q;
        if (reset || flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !drain)      state_d = ST_FULL;
                    else if (!accept && drain) state_d = ST_EMPTY;
                end
                ST_FULL:  if (drain) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    // Load the entries. Only control is cleared on reset/flush; data follows CLEAR_DATA.
    always_comb begin
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (reset || flush) begin
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs. Control is forced to zero in bubbles so downstream sees a NOP.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_ctrl  = out_valid ? main_ctrl_q : '0;
        out_data  = main_data_q;
        occupancy = state_q;
        in_ready  = in_ready_q;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed vector table for the handshake corner
// cases, then a long random valid/ready/flush/reset run checked against a queue model.

module tb_pipe_stage_skid;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 276;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int total = 0;
    int bad   = 0;

    pipe_stage_skid #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .CLEAR_DATA(1'b0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              fl;
        logic              iv;
        logic              ordy;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic              exp_valid;
        logic [CTRL_W-1:0] exp_ctrl;
        logic [1:0]        exp_occ;
        logic              exp_rdy;
        logic              chk_data;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    vec_t  vecs[$];
    beat_t model_q[$];

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic ordy,
                                logic [7:0] ctrl, logic [31:0] data,
                                logic ev, logic [7:0] ectrl, logic [1:0] eocc,
                                logic erdy, logic chk, logic [31:0] edata);
        vec_t v;
        v.rst       = rst;
        v.fl        = fl;
        v.iv        = iv;
        v.ordy      = ordy;
        v.ctrl      = ctrl;
        v.data      = DATA_W'(data);
        v.exp_valid = ev;
        v.exp_ctrl  = ectrl;
        v.exp_occ   = eocc;
        v.exp_rdy   = erdy;
        v.chk_data  = chk;
        v.exp_data  = DATA_W'(edata);
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) d[i] = 1'($urandom);
        return d;
    endfunction

    task automatic check_output(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(vec_t v);
        reset     = v.rst;
        flush     = v.fl;
        in_valid  = v.iv;
        out_ready = v.ordy;
        in_ctrl   = v.ctrl;
        in_data   = v.data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("reset_valid", DATA_W'(out_valid), '0);
        check_output("reset_ctrl",  DATA_W'(out_ctrl),  '0);
        check_output("reset_occ",   DATA_W'(occupancy), '0);
        check_output("reset_rdy",   DATA_W'(in_ready),  DATA_W'(1));
        reset = 1'b0;

        // Streaming: every beat comes out one cycle later, occupancy pinned at 1.
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0,0,1,1, 8'(k+1), 32'h100+k, 1, 8'(k+1), 1, 1, 1, 32'h100+k));
        vecs.push_back(mk(0,0,0,1, 8'h00, 0,    0, 8'h00, 0, 1, 0, 0));
        // Backpressure: A, B fill the stage, C held upstream, then A, B, C drain in order.
        vecs.push_back(mk(0,0,1,0, 8'h11, 32'hA, 1, 8'h11, 1, 1, 1, 32'hA));
        vecs.push_back(mk(0,0,1,0, 8'h22, 32'hB, 1, 8'h11, 2, 0, 1, 32'hA));
        vecs.push_back(mk(0,0,1,0, 8'h33, 32'hC, 1, 8'h11, 2, 0, 1, 32'hA));
        vecs.push_back(mk(0,0,1,1, 8'h33, 32'hC, 1, 8'h22, 1, 1, 1, 32'hB));
        vecs.push_back(mk(0,0,1,1, 8'h33, 32'hC, 1, 8'h33, 1, 1, 1, 32'hC));
        vecs.push_back(mk(0,0,0,1, 8'h33, 32'hC, 0, 8'h00, 0, 1, 0, 0));
        // Accept and drain together while holding one entry.
        vecs.push_back(mk(0,0,1,0, 8'h44, 32'h44, 1, 8'h44, 1, 1, 1, 32'h44));
        vecs.push_back(mk(0,0,1,1, 8'h55, 32'h55, 1, 8'h55, 1, 1, 1, 32'h55));
        vecs.push_back(mk(0,0,0,0, 8'h99, 32'h99, 1, 8'h55, 1, 1, 1, 32'h55));
        // Flush while full with a beat offered; the offered beat must vanish.
        vecs.push_back(mk(0,0,1,0, 8'h66, 32'h66, 1, 8'h55, 2, 0, 1, 32'h55));
        vecs.push_back(mk(0,1,1,0, 8'h77, 32'h77, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0,0,0,1, 8'h77, 32'h77, 0, 8'h00, 0, 1, 0, 0));
        // Reset while full, then a normal beat.
        vecs.push_back(mk(0,0,1,0, 8'h12, 32'h12, 1, 8'h12, 1, 1, 1, 32'h12));
        vecs.push_back(mk(0,0,1,0, 8'h13, 32'h13, 1, 8'h12, 2, 0, 1, 32'h12));
        vecs.push_back(mk(1,0,1,0, 8'h14, 32'h14, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(0,0,1,1, 8'h5A, 32'h5A, 1, 8'h5A, 1, 1, 1, 32'h5A));
        vecs.push_back(mk(0,0,0,1, 8'h00, 0,      0, 8'h00, 0, 1, 0, 0));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_valid", i), DATA_W'(out_valid), DATA_W'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d_ctrl", i),  DATA_W'(out_ctrl),  DATA_W'(vecs[i].exp_ctrl));
            check_output($sformatf("vec%0d_occ", i),   DATA_W'(occupancy), DATA_W'(vecs[i].exp_occ));
            check_output($sformatf("vec%0d_rdy", i),   DATA_W'(in_ready),  DATA_W'(vecs[i].exp_rdy));
            if (vecs[i].chk_data)
                check_output($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
        end

        // Random run against a FIFO model holding at most two beats.
        begin
            logic  exp_rdy;
            logic  acc;
            logic  drn;
            beat_t b;
            exp_rdy = 1'b1;
            model_q.delete();
            for (int cyc = 0; cyc < 10000; cyc++) begin
                reset     = ($urandom_range(0, 399) == 0);
                flush     = ($urandom_range(0, 59) == 0);
                in_valid  = ($urandom_range(0, 99) < 65);
                out_ready = ($urandom_range(0, 99) < 55);
                in_ctrl   = CTRL_W'($urandom);
                in_data   = rand_data();

                acc = in_valid && exp_rdy;
                drn = (model_q.size() > 0) && out_ready;
                if (reset || flush) begin
                    model_q.delete();
                end else begin
                    if (drn) void'(model_q.pop_front());
                    if (acc) begin
                        b.ctrl = in_ctrl;
                        b.data = in_data;
                        model_q.push_back(b);
                    end
                end
                exp_rdy = (model_q.size() < 2);

                @(posedge clk);
                #1;
                check_output("rnd_valid", DATA_W'(out_valid), DATA_W'(model_q.size() > 0));
                check_output("rnd_occ",   DATA_W'(occupancy), DATA_W'(model_q.size()));
                check_output("rnd_rdy",   DATA_W'(in_ready),  DATA_W'(exp_rdy));
                if (model_q.size() > 0) begin
                    check_output("rnd_ctrl", DATA_W'(out_ctrl), DATA_W'(model_q[0].ctrl));
                    check_output("rnd_data", out_data, model_q[0].data);
                end else begin
                    check_output("rnd_bubble_ctrl", DATA_W'(out_ctrl), '0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
